// File: rtl/alu_cmd_initiator.sv
// ALU command initiator: accepts one operation, drives the ALU bus, waits for the selected unit flag (with timeout), returns a packed response.
// Optional macro ALU_RSP_STATUS_EN adds RSP_ZERO / RSP_NEG status outputs.
module alu_cmd_initiator #(
   parameter int IN_DATA_WIDTH  = 16,
   parameter int RSP_DATA_WIDTH = 2*IN_DATA_WIDTH,
   parameter int CMP_OUT_WIDTH  = 3,
   parameter int ALU_LATENCY    = 1,
   parameter int TIMEOUT_CYCLES = 8
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      REQ_VALID,
   output logic                      REQ_READY,
   input  logic [IN_DATA_WIDTH-1:0]  REQ_A,
   input  logic [IN_DATA_WIDTH-1:0]  REQ_B,
   input  logic [3:0]                REQ_FUNC,
   output logic [IN_DATA_WIDTH-1:0]  ALU_A,
   output logic [IN_DATA_WIDTH-1:0]  ALU_B,
   output logic [3:0]                ALU_FUNC,
   input  logic [RSP_DATA_WIDTH-1:0] Arith_OUT,
   input  logic                      Arith_Flag,
   input  logic                      Carry_OUT,
   input  logic [IN_DATA_WIDTH-1:0]  Logic_OUT,
   input  logic                      Logic_Flag,
   input  logic [IN_DATA_WIDTH-1:0]  SHIFT_OUT,
   input  logic                      SHIFT_Flag,
   input  logic [CMP_OUT_WIDTH-1:0]  CMP_OUT,
   input  logic                      CMP_Flag,
   output logic                      RSP_VALID,
   input  logic                      RSP_READY,
   output logic [RSP_DATA_WIDTH-1:0] RSP_DATA,
   output logic                      RSP_CARRY,
`ifdef ALU_RSP_STATUS_EN
   output logic                      RSP_ERR,
   output logic                      RSP_ZERO,
   output logic                      RSP_NEG
`else
   output logic                      RSP_ERR
`endif
);

   localparam int CNT_RAW = $clog2(ALU_LATENCY + TIMEOUT_CYCLES + 1);
   localparam int CNT_W   = (CNT_RAW > 0) ? CNT_RAW : 1;
   localparam logic [CNT_W-1:0] LAT_C = CNT_W'(ALU_LATENCY);
   localparam logic [CNT_W-1:0] TMO_C = CNT_W'(ALU_LATENCY + TIMEOUT_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                    state, state_nxt;
   logic [CNT_W-1:0]          cnt;
   logic                      sel_flag, sel_carry, hit, tmo;
   logic [RSP_DATA_WIDTH-1:0] sel_data;
`ifdef ALU_RSP_STATUS_EN
   logic                      sel_neg;
`endif

   assign REQ_READY = (state == S_IDLE) && !RST;
   assign RSP_VALID = (state == S_RESP);

   // Unit select comes from the registered function, so it is fixed from acceptance on.
   always_comb begin
      sel_flag  = 1'b0;
      sel_data  = '0;
      sel_carry = 1'b0;
      case (ALU_FUNC[3:2])
         2'b00: begin
            sel_flag  = Arith_Flag;
            sel_data  = Arith_OUT;
            sel_carry = Carry_OUT;
         end
         2'b01: begin
            sel_flag = Logic_Flag;
            sel_data = RSP_DATA_WIDTH'(Logic_OUT);
         end
         2'b10: begin
            sel_flag = CMP_Flag;
            sel_data = RSP_DATA_WIDTH'(CMP_OUT);
         end
         2'b11: begin
            sel_flag = SHIFT_Flag;
            sel_data = RSP_DATA_WIDTH'(SHIFT_OUT);
         end
      endcase
   end

`ifdef ALU_RSP_STATUS_EN
   assign sel_neg = (ALU_FUNC[3:2] == 2'b00) && Arith_OUT[RSP_DATA_WIDTH-1];
`endif

   // Early WAIT cycles ignore the flag: it may still be the previous function's.
   assign hit = (state == S_WAIT) && (cnt >= LAT_C) && sel_flag;
   assign tmo = (state == S_WAIT) && (cnt == TMO_C) && !sel_flag;

   always_ff @(posedge CLK) begin
      if (RST) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (REQ_VALID)  state_nxt = S_WAIT;
         S_WAIT:  if (hit || tmo) state_nxt = S_RESP;
         S_RESP:  if (RSP_READY)  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         ALU_A     <= '0;
         ALU_B     <= '0;
         ALU_FUNC  <= '0;
         cnt       <= '0;
         RSP_DATA  <= '0;
         RSP_CARRY <= 1'b0;
         RSP_ERR   <= 1'b0;
`ifdef ALU_RSP_STATUS_EN
         RSP_ZERO  <= 1'b0;
         RSP_NEG   <= 1'b0;
`endif
      end else begin
         if (REQ_VALID && REQ_READY) begin
            ALU_A    <= REQ_A;
            ALU_B    <= REQ_B;
            ALU_FUNC <= REQ_FUNC;
            cnt      <= '0;
         end else if (state == S_WAIT) begin
            cnt <= cnt + 1'b1;
         end
         if (hit) begin
            RSP_DATA  <= sel_data;
            RSP_CARRY <= sel_carry;
            RSP_ERR   <= 1'b0;
`ifdef ALU_RSP_STATUS_EN
            RSP_ZERO  <= (sel_data == '0);
            RSP_NEG   <= sel_neg;
`endif
         end else if (tmo) begin
            RSP_DATA  <= '0;
            RSP_CARRY <= 1'b0;
            RSP_ERR   <= 1'b1;
`ifdef ALU_RSP_STATUS_EN
            RSP_ZERO  <= 1'b0;
            RSP_NEG   <= 1'b0;
`endif
         end
      end
   end

endmodule

// File: tb/tb_alu_cmd_initiator.sv
// Scoreboard bench for alu_cmd_initiator: the driver plays the ALU and pushes expected responses, a negedge monitor pops and checks them.
module tb_alu_cmd_initiator;

   logic        CLK = 1'b0, RST = 1'b1;
   logic        REQ_VALID = 1'b0, REQ_READY;
   logic [15:0] REQ_A = '0, REQ_B = '0;
   logic [3:0]  REQ_FUNC = '0;
   logic [15:0] ALU_A, ALU_B;
   logic [3:0]  ALU_FUNC;
   logic [31:0] Arith_OUT = '0;
   logic        Arith_Flag = 1'b0, Carry_OUT = 1'b0;
   logic [15:0] Logic_OUT = '0, SHIFT_OUT = '0;
   logic        Logic_Flag = 1'b0, SHIFT_Flag = 1'b0, CMP_Flag = 1'b0;
   logic [2:0]  CMP_OUT = '0;
   logic        RSP_VALID, RSP_READY = 1'b1;
   logic [31:0] RSP_DATA;
   logic        RSP_CARRY, RSP_ERR;

   alu_cmd_initiator dut (
      .CLK(CLK), .RST(RST),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
      .REQ_A(REQ_A), .REQ_B(REQ_B), .REQ_FUNC(REQ_FUNC),
      .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUNC(ALU_FUNC),
      .Arith_OUT(Arith_OUT), .Arith_Flag(Arith_Flag), .Carry_OUT(Carry_OUT),
      .Logic_OUT(Logic_OUT), .Logic_Flag(Logic_Flag),
      .SHIFT_OUT(SHIFT_OUT), .SHIFT_Flag(SHIFT_Flag),
      .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
      .RSP_DATA(RSP_DATA), .RSP_CARRY(RSP_CARRY), .RSP_ERR(RSP_ERR)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] data;
      logic        carry;
      logic        err;
      int          lat;
   } exp_t;

   exp_t sb[$];
   exp_t m_e;
   int   total = 0, bad = 0, cyc = 0, acc_cyc = 0;
   logic prev_vld = 1'b0;

   always @(posedge CLK) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // Monitor: latency on the rising edge of RSP_VALID, payload on handshake
   always @(negedge CLK) begin
      if (RST) prev_vld = 1'b0;
      else begin
         if (REQ_VALID && REQ_READY) acc_cyc = cyc;
         if (RSP_VALID && !prev_vld && sb.size() > 0)
            chk("latency", cyc - acc_cyc, sb[0].lat);
         if (RSP_VALID && RSP_READY) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_rsp actual=%h required=none", RSP_DATA);
            end else begin
               m_e = sb.pop_front();
               chk("rsp_data", RSP_DATA, m_e.data);
               chk("rsp_carry", 32'(RSP_CARRY), 32'(m_e.carry));
               chk("rsp_err", 32'(RSP_ERR), 32'(m_e.err));
            end
         end
         prev_vld = RSP_VALID;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   // Holds REQ_VALID until accepted; returns 1 at the cycle after acceptance (+#1).
   task automatic wait_accept(output logic acc);
      int g;
      g = 0;
      acc = 1'b0;
      while (!acc && g < 20) begin
         @(negedge CLK);
         acc = REQ_READY;
         @(posedge CLK); #1;
         g++;
      end
      REQ_VALID = 1'b0;
      if (!acc) begin
         total++;
         bad++;
         $display("FAIL accept_timeout actual=not_accepted required=accepted");
      end
   endtask

   // Flag of the selected unit is high in cycles acc+on .. acc+off; noise drives the other flags high.
   task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [3:0] f,
                         input logic [31:0] ao, input logic co, input logic [15:0] lo,
                         input logic [15:0] so, input logic [2:0] cmpo,
                         input int on, input int off, input logic noise,
                         input logic [31:0] ed, input logic ec, input logic ee, input int lat);
      exp_t e;
      logic acc, fl;
      e.data = ed; e.carry = ec; e.err = ee; e.lat = lat;
      sb.push_back(e);
      Arith_OUT = ao; Carry_OUT = co; Logic_OUT = lo; SHIFT_OUT = so; CMP_OUT = cmpo;
      @(posedge CLK); #1;
      REQ_A = a; REQ_B = b; REQ_FUNC = f; REQ_VALID = 1'b1;
      wait_accept(acc);
      if (!acc) begin
         void'(sb.pop_back());
         return;
      end
      chk("alu_a", 32'(ALU_A), 32'(a));
      chk("alu_b", 32'(ALU_B), 32'(b));
      chk("alu_func", 32'(ALU_FUNC), 32'(f));
      for (int k = 1; k <= 12; k++) begin
         fl = (k >= on) && (k <= off);
         Arith_Flag = noise; Logic_Flag = noise; CMP_Flag = noise; SHIFT_Flag = noise;
         case (f[3:2])
            2'b00: Arith_Flag = fl;
            2'b01: Logic_Flag = fl;
            2'b10: CMP_Flag   = fl;
            2'b11: SHIFT_Flag = fl;
         endcase
         @(posedge CLK); #1;
      end
      Arith_Flag = 1'b0; Logic_Flag = 1'b0; CMP_Flag = 1'b0; SHIFT_Flag = 1'b0;
   endtask

   logic acc0;

   initial begin
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_req_ready", 32'(REQ_READY), 32'd0);
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("idle_req_ready", 32'(REQ_READY), 32'd1);
      chk("idle_rsp_valid", 32'(RSP_VALID), 32'd0);
      chk("idle_alu_func", 32'(ALU_FUNC), 32'd0);
      chk("idle_rsp_data", RSP_DATA, 32'd0);
      chk("idle_rsp_err", 32'(RSP_ERR), 32'd0);

      //      a        b        f        Arith_OUT     Cy    Logic     Shift     Cmp     on  off nz   exp data      eC    eE    lat
      run_op(16'd5,   16'd7,   4'b0000, 32'd12,       1'b0, 16'h0,    16'h0,    3'b0,   2, 12, 1'b0, 32'd12,       1'b0, 1'b0, 3);
      run_op(16'd2,   16'd5,   4'b0001, 32'hFFFFFFFD, 1'b1, 16'h0,    16'h0,    3'b0,   2, 12, 1'b0, 32'hFFFFFFFD, 1'b1, 1'b0, 3);
      run_op(16'd4,   16'd9,   4'b1000, 32'h0,        1'b1, 16'h0,    16'h0,    3'b010, 2, 12, 1'b0, 32'h2,        1'b0, 1'b0, 3);
      run_op(16'hF0F0,16'hA5FF,4'b0100, 32'h55,       1'b1, 16'hA5F0, 16'h0,    3'b0,   3, 12, 1'b1, 32'h0000A5F0, 1'b0, 1'b0, 4);
      run_op(16'h8000,16'd1,   4'b1100, 32'h0,        1'b0, 16'h0,    16'h8001, 3'b0,   2, 12, 1'b0, 32'h00008001, 1'b0, 1'b0, 3);
      // Stale flag only in the first WAIT cycle, then timeout
      run_op(16'd1,   16'd2,   4'b0101, 32'h0,        1'b1, 16'h1234, 16'h0,    3'b0,   1, 1,  1'b0, 32'h0,        1'b0, 1'b1, 11);
      // Flag arrives exactly in the timeout cycle
      run_op(16'd3,   16'd3,   4'b0110, 32'h0,        1'b0, 16'h00FF, 16'h0,    3'b0,   10, 10, 1'b0, 32'h000000FF, 1'b0, 1'b0, 11);

      // Backpressure with a second request pending
      RSP_READY = 1'b0;
      run_op(16'd3,   16'd4,   4'b0000, 32'd7,        1'b0, 16'h0,    16'h0,    3'b0,   2, 12, 1'b0, 32'd7,        1'b0, 1'b0, 3);
      REQ_A = 16'd1; REQ_B = 16'd1; REQ_FUNC = 4'b0000; REQ_VALID = 1'b1;
      repeat (5) begin
         @(negedge CLK);
         chk("bp_rsp_valid", 32'(RSP_VALID), 32'd1);
         chk("bp_rsp_data", RSP_DATA, 32'd7);
         chk("bp_req_ready", 32'(REQ_READY), 32'd0);
      end
      @(posedge CLK); #1;
      RSP_READY = 1'b1;
      run_op(16'd1,   16'd1,   4'b0000, 32'd2,        1'b0, 16'h0,    16'h0,    3'b0,   2, 12, 1'b0, 32'd2,        1'b0, 1'b0, 3);

      // Reset pulsed in WAIT discards the operation
      Arith_OUT = 32'd99;
      @(posedge CLK); #1;
      REQ_A = 16'd50; REQ_B = 16'd49; REQ_FUNC = 4'b0000; REQ_VALID = 1'b1;
      wait_accept(acc0);
      RST = 1'b1;
      Arith_Flag = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("post_rst_req_ready", 32'(REQ_READY), 32'd1);
      chk("post_rst_rsp_valid", 32'(RSP_VALID), 32'd0);
      chk("post_rst_alu_a", 32'(ALU_A), 32'd0);
      repeat (3) @(posedge CLK);
      #1;
      Arith_Flag = 1'b0;
      run_op(16'd9,   16'd9,   4'b0000, 32'd18,       1'b0, 16'h0,    16'h0,    3'b0,   2, 12, 1'b0, 32'd18,       1'b0, 1'b0, 3);

      repeat (5) @(posedge CLK);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
